// File: rtl/maple_bus_sequencer.sv
// Maple Bus transaction sequencer: TX enable, bus turnaround guard,
// RX response window, and done/timeout reporting.
module maple_bus_sequencer #(
    parameter int C_TIMEOUT_WIDTH     = 20,
    parameter int C_TURNAROUND_CYCLES = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       expect_response,
    input  logic [C_TIMEOUT_WIDTH-1:0] resp_timeout,
    input  logic                       tx_pkt_avail,
    input  logic                       transmitting,
    input  logic                       receiving,
    input  logic                       rx_pkt_done,
    output logic                       enable_tx,
    output logic                       enable_rx,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [1:0]                 err_code
);

    localparam int W = C_TIMEOUT_WIDTH;
    localparam logic [W-1:0] GUARD_LAST = W'(C_TURNAROUND_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NO_DATA = 2'b01;
    localparam logic [1:0] ERR_TX_TMO  = 2'b10;
    localparam logic [1:0] ERR_RX_TMO  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_ARM,
        S_TX_ACTIVE,
        S_GUARD,
        S_RX_WAIT,
        S_RX_ACTIVE,
        S_DONE_OK,
        S_DONE_ERR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_nxt;
    logic [W-1:0]   cnt_inc;
    logic [W-1:0]   tmo_q;
    logic [W-1:0]   tmo_nxt;
    logic           exp_q;
    logic           exp_nxt;
    logic [1:0]     err_nxt;
    logic           tmo_hit;

    // Saturating count so a huge timeout can never wrap into a false hit.
    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign tmo_hit = (tmo_q != '0) && (cnt == tmo_q - 1'b1);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tmo_q     <= '0;
            exp_q     <= 1'b0;
            err_code  <= ERR_NONE;
            enable_tx <= 1'b0;
            enable_rx <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tmo_q     <= tmo_nxt;
            exp_q     <= exp_nxt;
            err_code  <= err_nxt;
            enable_tx <= (state_nxt == S_TX_ARM) ||
                         (state_nxt == S_TX_ACTIVE);
            enable_rx <= (state_nxt == S_RX_WAIT) ||
                         (state_nxt == S_RX_ACTIVE);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE_OK);
            timeout   <= (state_nxt == S_DONE_ERR);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo_q;
        exp_nxt   = exp_q;
        err_nxt   = err_code;

        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        exp_nxt = expect_response;
                        tmo_nxt = resp_timeout;
                        cnt_nxt = '0;
                        if (tx_pkt_avail) begin
                            err_nxt   = ERR_NONE;
                            state_nxt = S_TX_ARM;
                        end else begin
                            err_nxt   = ERR_NO_DATA;
                            state_nxt = S_DONE_ERR;
                        end
                    end
                end
                S_TX_ARM: begin
                    cnt_nxt = cnt_inc;
                    if (transmitting) begin
                        state_nxt = S_TX_ACTIVE;
                    end else if (tmo_hit) begin
                        err_nxt   = ERR_TX_TMO;
                        state_nxt = S_DONE_ERR;
                    end
                end
                S_TX_ACTIVE: begin
                    if (!transmitting) begin
                        cnt_nxt   = '0;
                        state_nxt = S_GUARD;
                    end
                end
                S_GUARD: begin
                    cnt_nxt = cnt_inc;
                    if (cnt == GUARD_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = exp_q ? S_RX_WAIT : S_DONE_OK;
                    end
                end
                S_RX_WAIT: begin
                    cnt_nxt = cnt_inc;
                    if (receiving) begin
                        state_nxt = S_RX_ACTIVE;
                    end else if (tmo_hit) begin
                        err_nxt   = ERR_RX_TMO;
                        state_nxt = S_DONE_ERR;
                    end
                end
                S_RX_ACTIVE: begin
                    if (rx_pkt_done) begin
                        state_nxt = S_DONE_OK;
                    end
                end
                S_DONE_OK:  state_nxt = S_IDLE;
                S_DONE_ERR: state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
